multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - Multicycle ALU: single-cycle logic/arith ops, iterative multiply/divide, HI/LO accumulators
//
// Optional feature: define MULTICYCLE_ALU_DIV_EN to build the radix-2 signed divider
// for opcode 1101. Without it, 1101 completes in one cycle with result 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       operation offer / block idle and able to accept
//   a, b, alu_op              operands and opcode, captured on acceptance
//   out_valid / out_ready     result held until consumer takes it
//   result                    operation result
//   zero, overflow,
//   carry_out, div_by_zero    status flags for the current result
//   hi, lo                    architectural HI/LO accumulator registers
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_SRA   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_MADD  = 4'b0011;
    localparam logic [3:0] OP_MADDU = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1000;
    localparam logic [3:0] OP_XOR   = 4'b1001;
    localparam logic [3:0] OP_SLT   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_LUI   = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_SLL   = 4'b1110;
    localparam logic [3:0] OP_SRL   = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q;
    logic                 a_neg_q, b_neg_q;
    logic [SW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   prod_q;    // {partial, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH-1:0]     mcand_q;   // multiplicand or divisor
    logic [WIDTH-1:0]     result_q, hi_q, lo_q;
    logic                 zero_q, ovf_q, carry_q, dbz_q;
`ifdef MULTICYCLE_ALU_DIV_EN
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0]     a_q;
    logic                 div0_q, dovf_q;
    logic [WIDTH:0]       div_trial, div_diff;
    logic [2*WIDTH-1:0]   div_step;
`endif

    logic                 accept, is_iter, last_step;
    logic [SW-1:0]        shamt;
    logic [WIDTH:0]       add_sum, sub_sum;
    logic [WIDTH-1:0]     sc_result, a_mag, b_mag, fin_hi, fin_lo;
    logic                 sc_carry, sc_ovf, fin_ovf, fin_dbz, mul_neg;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step, mul_prod, iter_step;

    assign accept    = in_valid & in_ready;
    assign last_step = (cnt_q == SW'(WIDTH - 1));

    always_comb begin
        is_iter = (alu_op == OP_MADD) || (alu_op == OP_MADDU) || (alu_op == OP_MUL);
`ifdef MULTICYCLE_ALU_DIV_EN
        if (alu_op == OP_DIV) is_iter = 1'b1;
`endif
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = is_iter ? S_BUSY : S_DONE;
            S_BUSY:  if (last_step) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
    end

    // Single-cycle datapath, evaluated on the live inputs in the acceptance cycle
    assign shamt   = a[SW-1:0];
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign a_mag   = a[WIDTH-1] ? -a : a;
    assign b_mag   = b[WIDTH-1] ? -b : b;

    always_comb begin
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sc_result = add_sum[WIDTH-1:0];
                sc_carry  = add_sum[WIDTH];
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = sub_sum[WIDTH-1:0];
                sc_carry  = sub_sum[WIDTH];   // 1 means no borrow
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_NOR:  sc_result = ~(a | b);
            OP_XOR:  sc_result = a ^ b;
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_LUI:  sc_result = WIDTH'({16'(b), 16'h0000});
            OP_SLL:  sc_result = b << shamt;
            OP_SRL:  sc_result = b >> shamt;
            OP_SRA:  sc_result = $signed(b) >>> shamt;
            default: sc_result = '0;
        endcase
    end

    // One shift-add multiply step: add multiplicand when multiplier LSB is set, shift right
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef MULTICYCLE_ALU_DIV_EN
    // One restoring divide step: shift in next dividend bit, subtract divisor if it fits
    assign div_trial = prod_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_trial - {1'b0, mcand_q};
    assign div_step  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  prod_q[WIDTH-2:0], 1'b1};
    assign iter_step = (op_q == OP_DIV) ? div_step : mul_step;
`else
    assign iter_step = mul_step;
`endif

    // Completion values, computed from the final iteration so the result lands on the last BUSY edge
    assign mul_neg  = (op_q != OP_MADDU) && (a_neg_q ^ b_neg_q);
    assign mul_prod = mul_neg ? -mul_step : mul_step;

    always_comb begin
        fin_ovf = 1'b0;
        fin_dbz = 1'b0;
        if (op_q == OP_MUL) {fin_hi, fin_lo} = mul_prod;
        else                {fin_hi, fin_lo} = {hi_q, lo_q} + mul_prod;
`ifdef MULTICYCLE_ALU_DIV_EN
        if (op_q == OP_DIV) begin
            if (div0_q) begin
                fin_lo  = '1;
                fin_hi  = a_q;
                fin_dbz = 1'b1;
            end else begin
                fin_lo  = (a_neg_q ^ b_neg_q) ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
                fin_hi  = a_neg_q ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
                fin_ovf = dovf_q;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            a_q      <= '0;
            div0_q   <= 1'b0;
            dovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            op_q    <= alu_op;
            a_neg_q <= a[WIDTH-1];
            b_neg_q <= b[WIDTH-1];
            cnt_q   <= '0;
            // Signed ops iterate on magnitudes; the sign is restored at completion
            if (alu_op == OP_MADDU) begin
                mcand_q <= b;
                prod_q  <= {{WIDTH{1'b0}}, a};
            end else begin
                mcand_q <= b_mag;
                prod_q  <= {{WIDTH{1'b0}}, a_mag};
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            a_q    <= a;
            div0_q <= (b == '0);
            dovf_q <= (a == MIN_V) && (b == '1);
`endif
            if (!is_iter) begin
                result_q <= sc_result;
                zero_q   <= (sc_result == '0);
                ovf_q    <= sc_ovf;
                carry_q  <= sc_carry;
                dbz_q    <= 1'b0;
            end
        end else if (state_q == S_BUSY) begin
            prod_q <= iter_step;
            cnt_q  <= cnt_q + SW'(1);
            if (last_step) begin
                hi_q     <= fin_hi;
                lo_q     <= fin_lo;
                result_q <= fin_lo;
                zero_q   <= (fin_lo == '0);
                ovf_q    <= fin_ovf;
                carry_q  <= 1'b0;
                dbz_q    <= fin_dbz;
            end
        end
    end

    assign result      = result_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign carry_out   = carry_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - Directed self-checking bench for multicycle_alu (WIDTH 32 and 8)
module tb_multicycle_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result, hi, lo;
    logic [3:0]  alu_op;
    logic        zero, overflow, carry_out, div_by_zero;

    logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8;
    logic [7:0]  a_8, b_8, result_8, hi_8, lo_8;
    logic [3:0]  alu_op_8;
    logic        zero_8, overflow_8, carry_out_8, div_by_zero_8;

    int n_err = 0;
    int n_checks = 0;
    int lat;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .carry_out(carry_out),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    multicycle_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a(a_8), .b(b_8), .alu_op(alu_op_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .result(result_8), .zero(zero_8), .overflow(overflow_8), .carry_out(carry_out_8),
        .div_by_zero(div_by_zero_8), .hi(hi_8), .lo(lo_8)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] av, bv, r;
        logic        c, v;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offers one op, then waits (bounded) for out_valid; leaves the result pending.
    task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("in_ready_before_op", 64'(in_ready), 64'd1);
        in_valid = 1'b1; a = av; b = bv; alu_op = op;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = ~av; b = ~bv; alu_op = ~op;
        n = 1;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        lat = n;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] exp, input int exp_lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready_8 && n < 100) begin @(negedge clk); n++; end
        in_valid_8 = 1'b1; a_8 = av; b_8 = bv; alu_op_8 = op;
        @(posedge clk);
        @(negedge clk);
        in_valid_8 = 1'b0;
        n = 1;
        while (!out_valid_8 && n < 100) begin @(negedge clk); n++; end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check(tag, 64'(result_8), 64'(exp));
        out_ready_8 = 1'b1;
        @(posedge clk);
        #1 out_ready_8 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        vecs = '{
            '{4'h1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1},
            '{4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0},
            '{4'h2, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0},
            '{4'h2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1},
            '{4'h2, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0},
            '{4'h6, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0, 1'b0},
            '{4'h7, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0},
            '{4'h8, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0},
            '{4'h9, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b0},
            '{4'hA, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
            '{4'hB, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0},
            '{4'hC, 32'h00000000, 32'h1234ABCD, 32'hABCD0000, 1'b0, 1'b0},
            '{4'hE, 32'h00000004, 32'h00000001, 32'h00000010, 1'b0, 1'b0},
            '{4'hE, 32'h00000021, 32'h00000001, 32'h00000002, 1'b0, 1'b0},
            '{4'hF, 32'h0000001F, 32'h80000000, 32'h00000001, 1'b0, 1'b0},
            '{4'h0, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0}
        };

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; alu_op = '0;
        in_valid_8 = 1'b0; out_ready_8 = 1'b0; a_8 = '0; b_8 = '0; alu_op_8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // mul -3 * 7
        run_op(4'h5, 32'hFFFFFFFD, 32'h00000007);
        check("mul_lat", 64'(lat), 64'd33);
        check("mul_hi", 64'(hi), 64'hFFFFFFFF);
        check("mul_lo", 64'(lo), 64'hFFFFFFEB);
        check("mul_result", 64'(result), 64'hFFFFFFEB);
        check("mul_flags", {61'd0, zero, overflow, carry_out}, 64'd0);
        take();

        // maddu 0xFFFFFFFF * 2 added to -21: 0x1_FFFFFFE9
        run_op(4'h4, 32'hFFFFFFFF, 32'h00000002);
        check("maddu_lat", 64'(lat), 64'd33);
        check("maddu_hilo", {hi, lo}, 64'h00000001_FFFFFFE9);
        check("maddu_result", 64'(result), 64'hFFFFFFE9);
        take();

        // madd -2 * 3 added: 0x1_FFFFFFE3
        run_op(4'h3, 32'hFFFFFFFE, 32'h00000003);
        check("madd_lat", 64'(lat), 64'd33);
        check("madd_hilo", {hi, lo}, 64'h00000001_FFFFFFE3);
        take();

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].av, vecs[i].bv);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'd1);
            check($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].r));
            check($sformatf("v%0d_zero", i), 64'(zero), 64'(vecs[i].r == 32'd0));
            check($sformatf("v%0d_carry", i), 64'(carry_out), 64'(vecs[i].c));
            check($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].v));
            check($sformatf("v%0d_hilo", i), {hi, lo}, 64'h00000001_FFFFFFE3);
            take();
        end

`ifdef MULTICYCLE_ALU_DIV_EN
        run_op(4'hD, 32'hFFFFFFF9, 32'h00000002);
        check("div_lat", 64'(lat), 64'd33);
        check("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        check("div_result", 64'(result), 64'hFFFFFFFD);
        take();
        run_op(4'hD, 32'h00000005, 32'h00000000);
        check("div0_lat", 64'(lat), 64'd33);
        check("div0_hilo", {hi, lo}, 64'h00000005_FFFFFFFF);
        check("div0_flag", 64'(div_by_zero), 64'd1);
        take();
        run_op(4'hD, 32'h80000000, 32'hFFFFFFFF);
        check("divmin_hilo", {hi, lo}, 64'h00000000_80000000);
        check("divmin_ovf", 64'(overflow), 64'd1);
        check("divmin_dbz", 64'(div_by_zero), 64'd0);
        take();
`else
        run_op(4'hD, 32'h00000005, 32'h00000000);
        check("nodiv_lat", 64'(lat), 64'd1);
        check("nodiv_result", 64'(result), 64'd0);
        check("nodiv_zero", 64'(zero), 64'd1);
        check("nodiv_dbz", 64'(div_by_zero), 64'd0);
        check("nodiv_hilo", {hi, lo}, 64'h00000001_FFFFFFE3);
        take();
`endif

        // Output stall: result held, new offer refused
        run_op(4'h1, 32'd1, 32'd2);
        check("stall_lat", 64'(lat), 64'd1);
        in_valid = 1'b1; a = 32'd99; b = 32'd1; alu_op = 4'h1;
        for (int i = 0; i < 10; i++) begin
            check("stall_result", 64'(result), 64'd3);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        take();
        run_op(4'h1, 32'd10, 32'd20);
        check("after_stall_result", 64'(result), 64'd30);
        take();

        // Reset during a mul aborts it
        @(negedge clk);
        in_valid = 1'b1; a = 32'hFFFFFFFD; b = 32'd7; alu_op = 4'h5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready_rst", 64'(in_ready), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);

        // WIDTH=8 instance
        run8("w8_sra", 4'h0, 8'h03, 8'h90, 8'hF2, 1);
        run8("w8_sll", 4'hE, 8'h09, 8'h01, 8'h02, 1);
        run8("w8_mul", 4'h5, 8'hFD, 8'h07, 8'hEB, 9);
        check("w8_mul_hi", 64'(hi_8), 64'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
